// File: rtl/i2s_tx_unpacker.sv
// I2S TX sample unpacker.
// Splits 32-bit bus words carrying packed PCM (4x8, 2x16, 1x24 or 1x32 bits)
// into one left-justified 32-bit sample per output beat for the TX FIFO.
// Width and sub-word order are captured with each word, so software may
// reprogram them while a word is still draining.
module i2s_tx_unpacker (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic [1:0]  dtl_i,
  input  logic        ord_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [1:0]  out_idx_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    W8  = 2'b00,
    W16 = 2'b01,
    W24 = 2'b10,
    W32 = 2'b11
  } width_e;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] word_q;
  width_e      width_q;
  logic        ord_q;
  logic [1:0]  k_q;
  logic [31:0] data_q;

  logic fire;
  logic last;
  logic accept;

  // Index of the final sub-word in a word of the given width (N-1).
  function automatic logic [1:0] last_idx(input width_e w);
    case (w)
      W8:      last_idx = 2'd3;
      W16:     last_idx = 2'd1;
      default: last_idx = 2'd0;
    endcase
  endfunction

  // Left-justified sample for logical sub-word k of word w.
  function automatic logic [31:0] pick(input logic [31:0] w, input width_e wd,
                                       input logic ord, input logic [1:0] k);
    logic [1:0] p;
    // NOTE: every variable gets a value before any branch, so no path can
    // leave it holding a stale value (which would otherwise infer a latch).
    pick = '0;
    p    = ord ? (last_idx(wd) - k) : k;
    case (wd)
      W8:  pick = {w[{p, 3'b000} +: 8], 24'h0};
      W16: pick = {w[{p[0], 4'b0000} +: 16], 16'h0};
      W24: pick = {w[23:0], 8'h0};
      W32: pick = w;
    endcase
  endfunction

  // Handshake terms; flush blocks acceptance so it always wins.
  assign fire       = out_valid_o && out_ready_i;
  assign last       = (k_q == last_idx(width_q));
  assign in_ready_o = en_i && !flush_i && ((state_q == EMPTY) || (fire && last));
  assign accept     = in_valid_i && in_ready_o;

  // Word hold / sub-word sequencing FSM with a registered sample output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      // NOTE: the held word and sample register are reset because the idle
      // output must read zero; they are plain flops, not a memory array.
      word_q  <= '0;
      width_q <= W8;
      ord_q   <= 1'b0;
      k_q     <= '0;
      data_q  <= '0;
    end else if (flush_i) begin
      // NOTE: non-blocking assignments throughout, so every flop samples
      // pre-edge values regardless of statement order.
      state_q <= EMPTY;
      word_q  <= '0;
      k_q     <= '0;
      data_q  <= '0;
    end else if (accept) begin
      state_q <= HOLD;
      word_q  <= in_data_i;
      width_q <= width_e'(dtl_i);
      ord_q   <= ord_i;
      k_q     <= '0;
      data_q  <= pick(in_data_i, width_e'(dtl_i), ord_i, 2'd0);
    end else if (fire) begin
      if (last) begin
        state_q <= EMPTY;
        k_q     <= '0;
        data_q  <= '0;
      end else begin
        k_q     <= k_q + 2'd1;
        data_q  <= pick(word_q, width_q, ord_q, k_q + 2'd1);
      end
    end
  end

  assign out_valid_o = (state_q == HOLD);
  assign busy_o      = (state_q == HOLD);
  assign out_data_o  = data_q;
  assign out_idx_o   = k_q;

endmodule

// File: tb/tb_i2s_tx_unpacker.sv
// Testbench for i2s_tx_unpacker: directed scenarios plus a randomized phase,
// all beats checked by a scoreboard fed from an arithmetic reference model.
module tb_i2s_tx_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic [1:0]  dtl;
  logic        ord;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_idx;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  i2s_tx_unpacker dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .flush_i     (flush),
    .dtl_i       (dtl),
    .ord_i       (ord),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: width in bits, N = 32/bits for 8/16 else 1, sample j
  // comes from physical slot p (reversed when ord=1), shifted to the top.
  task automatic push_word(input logic [31:0] w, input logic [1:0] d, input logic o);
    int          bits;
    int          n;
    int          p;
    logic [63:0] v;
    beat_t       b;
    bits = (int'(d) + 1) * 8;
    n    = (bits <= 16) ? (32 / bits) : 1;
    for (int j = 0; j < n; j++) begin
      p      = o ? (n - 1 - j) : j;
      v      = ({32'h0, w} >> (bits * p)) & ((64'd1 << bits) - 64'd1);
      v      = v << (32 - bits);
      b.data = v[31:0];
      b.idx  = 2'(j);
      sb.push_back(b);
    end
  endtask

  // Stimulus side of the scoreboard: every accepted word queues its beats.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) push_word(in_data, dtl, ord);
  end

  // Monitor: pops and compares every completed output beat.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n || flush) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb unexpected beat: got 0x%08h idx %0d with nothing expected", out_data, out_idx);
      end else begin
        e = sb.pop_front();
        check("sb data", out_data, e.data);
        check("sb idx", 32'(out_idx), 32'(e.idx));
        check("sb busy", 32'(busy), 32'd1);
      end
    end
  end

  // Hold in_valid until the word is taken (bounded), then drop it.
  task automatic wait_accept();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    check("accept timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w, input logic [1:0] d, input logic o);
    @(posedge clk);
    #1;
    in_data  = w;
    dtl      = d;
    ord      = o;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (!out_valid && sb.size() == 0) done = 1'b1;
    end
    check("drain timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] first;
    logic [31:0] exp8[4];
    logic        accepted;

    rst_n     = 1'b0;
    en        = 1'b1;
    flush     = 1'b0;
    dtl       = 2'b00;
    ord       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", out_data, 32'h0);
    check("rst out_idx", 32'(out_idx), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready en1", 32'(in_ready), 32'd1);
    en = 1'b0;
    #1;
    check("rst in_ready en0", 32'(in_ready), 32'd0);
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // 16-bit, LSB first
    issue(32'hAAAA5555, 2'b01, 1'b0);
    @(negedge clk);
    check("t1 valid", 32'(out_valid), 32'd1);
    check("t1 beat0", out_data, 32'h55550000);
    check("t1 idx0", 32'(out_idx), 32'd0);
    @(negedge clk);
    check("t1 beat1", out_data, 32'hAAAA0000);
    check("t1 idx1", 32'(out_idx), 32'd1);
    check("t1 in_ready last", 32'(in_ready), 32'd1);
    drain();

    // 8-bit, MSB first
    exp8[0] = 32'h11000000;
    exp8[1] = 32'h22000000;
    exp8[2] = 32'h33000000;
    exp8[3] = 32'h44000000;
    issue(32'h11223344, 2'b00, 1'b1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("t2 beat", out_data, exp8[j]);
      check("t2 idx", 32'(out_idx), 32'(j));
    end
    drain();

    // Back-to-back 32-bit words, zero bubbles
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) begin
      in_data  = 32'(i);
      dtl      = 2'b11;
      ord      = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      check("t3 in_ready", 32'(in_ready), 32'd1);
      if (i > 1) begin
        check("t3 valid", 32'(out_valid), 32'd1);
        check("t3 data", out_data, 32'(i - 1));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t3 valid last", 32'(out_valid), 32'd1);
    check("t3 data last", out_data, 32'd3);
    @(negedge clk);
    check("t3 empty", 32'(out_valid), 32'd0);

    // Stall: output stable, no acceptance while stalled
    w         = $urandom;
    first     = (w & 32'hFF) << 24;
    out_ready = 1'b0;
    issue(w, 2'b00, 1'b0);
    in_valid  = 1'b1;
    in_data   = $urandom;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("t4 valid", 32'(out_valid), 32'd1);
      check("t4 data stable", out_data, first);
      check("t4 in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Flush after one beat with a simultaneous offered word
    issue(32'hDEADBEEF, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hCAFE1234;
    dtl      = 2'b01;
    ord      = 1'b1;
    @(negedge clk);
    check("t5 in_ready flush", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t5 flushed valid", 32'(out_valid), 32'd0);
    check("t5 in_ready flush2", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_accept();
    @(negedge clk);
    check("t5 new beat0", out_data, 32'hCAFE0000);
    drain();

    // Width changed mid-word
    issue(32'hA1B2C3D4, 2'b00, 1'b0);
    dtl = 2'b11;
    issue(32'h12345678, 2'b11, 1'b0);
    drain();

    // Reset mid-word discards everything
    out_ready = 1'b0;
    issue(32'h55667788, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7 rst valid", 32'(out_valid), 32'd0);
    check("t7 rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t7 no partial", 32'(out_valid), 32'd0);

    // Randomized traffic with backpressure, enable and occasional flush
    accepted = 1'b0;
    repeat (800) begin
      @(posedge clk);
      #1;
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = $urandom;
        dtl      = 2'($urandom_range(0, 3));
        ord      = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 4) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      @(negedge clk);
      accepted = in_valid && in_ready;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    drain();
    check("sb empty at end", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx_unpacker.md
Name: i2s_tx_unpacker

Overview:
- Upstream feeder for the I2S transmit FIFO.
- Accepts 32-bit bus words that carry packed PCM samples: four 8-bit, two 16-bit, or one 24/32-bit sample per word.
- Emits one left-justified 32-bit sample per output beat, in the format the TX FIFO and serializer expect.
- Lets software move 2-4x more audio per bus write at 8/16-bit widths.

Parameters:
- None. Data width is fixed at 32 bits.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- en_i  in  1  enables acceptance of new input words.
- flush_i  in  1  synchronous clear of the held word and sub-word counter.
- dtl_i  in  2  sample width: 00=8, 01=16, 10=24, 11=32 bits.
- ord_i  in  1  0 = least-significant sub-word first; 1 = most-significant sub-word first.
- in_valid_i  in  1  packed input word valid.
- in_ready_o  out  1  unpacker can take a word this cycle.
- in_data_i  in  32  packed input word.
- out_valid_o  out  1  sample available.
- out_ready_i  in  1  downstream accepts the sample (TX FIFO not full).
- out_data_o  out  32  left-justified sample; bits below the sample width are zero.
- out_idx_o  out  2  sub-word index of the current sample within its source word.
- busy_o  out  1  a word is held (out_valid_o).

Behaviour:
- Reset (rst_n_i low, asynchronous): held word = 0, counter = 0, latched width = 8-bit code, latched order = 0. out_valid_o=0, out_data_o=0, out_idx_o=0, busy_o=0. in_ready_o follows the ready equation and so equals en_i.
- State: a held 32-bit word register, latched width and order, a 2-bit sub-word counter k, and a 1-bit state EMPTY/HOLD.
- Sub-word count per word N: 4 for 8-bit, 2 for 16-bit, 1 for 24-bit, 1 for 32-bit.
- dtl_i and ord_i are latched at word acceptance. Changing them mid-word does not affect the word in flight.
- Input handshake: a word is accepted when in_valid_i && in_ready_o.
- in_ready_o = en_i && (EMPTY || (out_valid_o && out_ready_i && k==N-1)). This gives zero-bubble back-to-back operation.
- Latency: word accepted in cycle t gives first sample on out_valid_o in cycle t+1. Output is registered; no combinational in->out path.
- Output handshake: a sample completes when out_valid_o && out_ready_i. On completion, k increments. At k==N-1, either load the next word (if one is accepted in the same cycle, k=0) or go to EMPTY.
- out_valid_o and out_data_o are stable while out_ready_i is low.
- Sub-word selection: physical index p = ord ? (N-1-k) : k.
  - 8-bit: out_data_o = {word[8p+7:8p], 24'b0}.
  - 16-bit: out_data_o = {word[16p+15:16p], 16'b0}.
  - 24-bit: out_data_o = {word[23:0], 8'b0}.
  - 32-bit: out_data_o = word.
  - out_idx_o = k.
- en_i low: no new words accepted; a held word keeps draining to completion.
- flush_i high: next edge goes to EMPTY, k=0, out_valid_o=0, and the held word is discarded. flush_i overrides a simultaneous acceptance: in_ready_o is forced 0 while flush_i is high.
- Reset mid-word: all samples of the held word are lost; no partial output after reset deasserts.
- busy_o = HOLD state (equals out_valid_o).

Test Plan:
- 16-bit, ord=0, word 0xAAAA5555, out_ready held 1 -> two beats, 0x55550000 (idx0) then 0xAAAA0000 (idx1); in_ready_o high in the second beat's cycle.
- 8-bit, ord=1, word 0x11223344 -> beats 0x11000000, 0x22000000, 0x33000000, 0x44000000, idx 0..3.
- Back-to-back 32-bit words 0x1, 0x2, 0x3 with in_valid and out_ready held 1 -> one sample per cycle, no bubbles, first output one cycle after the first acceptance.
- 8-bit word, out_ready_i low for 5 cycles after the first beat -> out_data_o stays 0x..000000 (first sub-word) and stable; in_ready_o=0 throughout; then drains the remaining 3 beats.
- flush_i asserted after 1 of 4 beats, with in_valid_i high in the same cycle -> out_valid_o=0 next cycle, in_ready_o=0 while flush_i is high, no remaining beats, new word accepted after flush_i drops.
- dtl_i switched from 8-bit to 32-bit mid-word -> the remaining 8-bit beats complete unchanged; the next word emits a single 32-bit beat.
